// File: rtl/ack_fifo_sync_if.sv
// ---------------------------------------------------------------------------
// ack_fifo_sync_if
// Bundles the access and status signals of ack_fifo_sync.
//   master : the FIFO user (drives CLR/WE/DATA/RE, observes data and flags)
//   slave  : the FIFO itself
// Signals:
//   CLR        synchronous flush, active high
//   WE/DATA    write request and write word
//   RE         read/pop request
//   Q/DVLD     read word and its valid indication
//   FULL/EMPTY/AFULL/AEMPTY  occupancy flags
//   COUNT      words held
//   OVERFLOW/UNDERFLOW       one-cycle rejected-access pulses
//   ERR_STICKY [1] overflow seen, [0] underflow seen
// ---------------------------------------------------------------------------
interface ack_fifo_sync_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             CLR;
  logic             WE;
  logic [WIDTH-1:0] DATA;
  logic             RE;
  logic [WIDTH-1:0] Q;
  logic             DVLD;
  logic             FULL;
  logic             EMPTY;
  logic             AFULL;
  logic             AEMPTY;
  logic [CW-1:0]    COUNT;
  logic             OVERFLOW;
  logic             UNDERFLOW;
  logic [1:0]       ERR_STICKY;

  modport master (
    output CLR, WE, DATA, RE,
    input  Q, DVLD, FULL, EMPTY, AFULL, AEMPTY, COUNT,
           OVERFLOW, UNDERFLOW, ERR_STICKY
  );

  modport slave (
    input  CLR, WE, DATA, RE,
    output Q, DVLD, FULL, EMPTY, AFULL, AEMPTY, COUNT,
           OVERFLOW, UNDERFLOW, ERR_STICKY
  );
endinterface

// File: rtl/ack_fifo_sync.sv
// ---------------------------------------------------------------------------
// ack_fifo_sync
// Single-clock FIFO for the acknowledge path between the HDC classifier core
// and the radio. Supports first-word-fall-through (FWFT=1) or standard
// registered read (FWFT=0), programmable almost-full/almost-empty levels,
// occupancy count, overflow/underflow pulses with sticky error bits and a
// synchronous flush.
// Ports:
//   CLK    rising-edge clock
//   RESET  asynchronous active-low reset (release synchronised internally)
//   bus    ack_fifo_sync_if.slave: CLR, WE, DATA, RE in; Q, DVLD, FULL,
//          EMPTY, AFULL, AEMPTY, COUNT, OVERFLOW, UNDERFLOW, ERR_STICKY out
// ---------------------------------------------------------------------------
module ack_fifo_sync #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int FWFT  = 1,
  parameter int AFVAL = 60,
  parameter int AEVAL = 3
) (
  input  logic           CLK,
  input  logic           RESET,
  ack_fifo_sync_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam bit FW = (FWFT != 0);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AFVAL);
  localparam logic [CW-1:0] AE_C    = CW'(AEVAL);

  logic             ready;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] q;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nx;
  logic [CW-1:0]    avail;
  logic             head_vld;
  logic             head_vld_nx;
  logic             full;
  logic             empty;
  logic             afull;
  logic             aempty;
  logic             dvld;
  logic             ovf;
  logic             udf;
  logic [1:0]       sticky;
  logic             active;
  logic             flush;
  logic             wr_ok;
  logic             rd_ok;
  logic             ovf_req;
  logic             udf_req;
  logic             load;
  logic             empty_nx;
  logic             dvld_nx;

  // Reset release synchroniser: the core ignores the edge on which this
  // flop first captures 1, so the first access lands on the second edge.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ready <= 1'b0;
    end else begin
      ready <= 1'b1;
    end
  end

  // Access decode: acceptance uses the registered FULL/EMPTY, so a read in
  // the same cycle never frees room for a write and vice versa.
  always_comb begin
    active  = ready & ~bus.CLR;
    flush   = ready & bus.CLR;
    wr_ok   = active & bus.WE & ~full;
    rd_ok   = active & bus.RE & ~empty;
    ovf_req = active & bus.WE & full;
    udf_req = active & bus.RE & empty;
  end

  always_comb begin
    count_nx = count;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_nx = count + CW'(1);
      2'b01:   count_nx = count - CW'(1);
      default: count_nx = count;
    endcase
  end

  // Read-side control. In FWFT mode the head register holds one word that
  // is still counted in COUNT; 'avail' is what remains in the array. Only
  // words written before this edge are in avail, so the array is never read
  // and written at the same address on one edge.
  always_comb begin
    avail = count - CW'(head_vld);
    if (FW) begin
      load        = active & (avail != '0) & (~head_vld | rd_ok);
      head_vld_nx = load | (head_vld & ~rd_ok);
      empty_nx    = ~head_vld_nx;
      dvld_nx     = head_vld_nx;
    end else begin
      load        = rd_ok;
      head_vld_nx = 1'b0;
      empty_nx    = (count_nx == '0);
      dvld_nx     = rd_ok;
    end
  end

  // Control and flag registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      head_vld <= 1'b0;
      full     <= 1'b0;
      empty    <= 1'b1;
      afull    <= 1'b0;
      aempty   <= 1'b1;
      dvld     <= 1'b0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
      sticky   <= 2'b00;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      head_vld <= 1'b0;
      full     <= 1'b0;
      empty    <= 1'b1;
      afull    <= 1'b0;
      aempty   <= 1'b1;
      dvld     <= 1'b0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
      sticky   <= 2'b00;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (load)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count_nx;
      head_vld <= head_vld_nx;
      full     <= (count_nx == DEPTH_C);
      empty    <= empty_nx;
      afull    <= (count_nx >= AF_C);
      aempty   <= (count_nx <= AE_C);
      dvld     <= dvld_nx;
      ovf      <= ovf_req;
      udf      <= udf_req;
      sticky   <= sticky | {ovf_req, udf_req};
    end
  end

  // Storage array: plain write port, registered read port (block RAM style)
  always_ff @(posedge CLK) begin
    if (wr_ok) mem[wr_ptr] <= bus.DATA;
  end

  // Read data register: head word in FWFT mode, read result in standard mode.
  // Retained across flush.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      q <= '0;
    end else if (load) begin
      q <= mem[rd_ptr];
    end
  end

  assign bus.Q          = q;
  assign bus.DVLD       = dvld;
  assign bus.FULL       = full;
  assign bus.EMPTY      = empty;
  assign bus.AFULL      = afull;
  assign bus.AEMPTY     = aempty;
  assign bus.COUNT      = count;
  assign bus.OVERFLOW   = ovf;
  assign bus.UNDERFLOW  = udf;
  assign bus.ERR_STICKY = sticky;

endmodule

// File: tb/tb_ack_fifo_sync.sv
// ---------------------------------------------------------------------------
// tb_ack_fifo_sync
// Two instances: 32x64 FWFT (defaults) and 8x4 standard-read. One is active
// at a time; a queue-based reference model predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_ack_fifo_sync;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ack_fifo_sync_if #(.WIDTH(32), .DEPTH(64)) ia ();
  ack_fifo_sync_if #(.WIDTH(8),  .DEPTH(4))  ib ();

  ack_fifo_sync #(.WIDTH(32), .DEPTH(64), .FWFT(1), .AFVAL(60), .AEVAL(3))
    dut_a (.CLK(clk), .RESET(rst_n), .bus(ia));

  ack_fifo_sync #(.WIDTH(8), .DEPTH(4), .FWFT(0), .AFVAL(3), .AEVAL(1))
    dut_b (.CLK(clk), .RESET(rst_n), .bus(ib));

  typedef struct {
    logic [31:0] d;
    int          e;
  } ent_t;

  int checks = 0;
  int errors = 0;

  // model configuration (selects which instance is exercised)
  int          sel;
  bit          m_fwft;
  int          m_depth;
  int          m_af;
  int          m_ae;
  logic [31:0] m_mask;

  // model state
  ent_t        mq[$];
  int          edge_n;
  bit          m_ready;
  bit          m_empty;
  bit          m_dvld;
  bit          m_ovf;
  bit          m_udf;
  logic [1:0]  m_sticky;
  logic [31:0] m_q;

  // last observed outputs
  logic [31:0] o_q;
  logic [31:0] o_cnt;
  logic        o_em, o_dv, o_fu, o_af, o_ae, o_ov, o_ud;
  logic [1:0]  o_st;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    edge_n   = 0;
    m_ready  = 1'b0;
    m_empty  = 1'b1;
    m_dvld   = 1'b0;
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
    m_sticky = 2'b00;
    m_q      = '0;
  endfunction

  function automatic void model_edge(input bit we, input logic [31:0] d,
                                     input bit re, input bit clr);
    ent_t        h;
    logic [31:0] popped;
    bit          full_b, wr, rd;
    popped = '0;
    edge_n++;
    if (!m_ready) begin
      m_ready = 1'b1;
      return;
    end
    if (clr) begin
      mq.delete();
      m_sticky = 2'b00;
      m_ovf    = 1'b0;
      m_udf    = 1'b0;
      m_dvld   = 1'b0;
      m_empty  = 1'b1;
      return;
    end
    full_b   = (mq.size() == m_depth);
    wr       = we && !full_b;
    rd       = re && !m_empty;
    m_ovf    = we && full_b;
    m_udf    = re && m_empty;
    m_sticky = m_sticky | {m_ovf, m_udf};
    if (rd) begin
      h      = mq.pop_front();
      popped = h.d;
    end
    if (wr) begin
      h.d = d & m_mask;
      h.e = edge_n;
      mq.push_back(h);
    end
    if (m_fwft) begin
      // a word becomes the visible head only on an edge after it was written
      m_empty = !(mq.size() > 0 && mq[0].e < edge_n);
      if (!m_empty) m_q = mq[0].d;
      m_dvld = !m_empty;
    end else begin
      m_empty = (mq.size() == 0);
      m_dvld  = rd;
      if (rd) m_q = popped;
    end
  endfunction

  task automatic check_all();
    if (sel == 0) begin
      o_q = ia.Q; o_cnt = 32'(ia.COUNT); o_em = ia.EMPTY; o_dv = ia.DVLD;
      o_fu = ia.FULL; o_af = ia.AFULL; o_ae = ia.AEMPTY; o_ov = ia.OVERFLOW;
      o_ud = ia.UNDERFLOW; o_st = ia.ERR_STICKY;
    end else begin
      o_q = 32'(ib.Q); o_cnt = 32'(ib.COUNT); o_em = ib.EMPTY; o_dv = ib.DVLD;
      o_fu = ib.FULL; o_af = ib.AFULL; o_ae = ib.AEMPTY; o_ov = ib.OVERFLOW;
      o_ud = ib.UNDERFLOW; o_st = ib.ERR_STICKY;
    end
    chk("Q",          o_q,        m_q);
    chk("COUNT",      o_cnt,      32'(mq.size()));
    chk("EMPTY",      32'(o_em),  32'(m_empty));
    chk("DVLD",       32'(o_dv),  32'(m_dvld));
    chk("FULL",       32'(o_fu),  32'(mq.size() == m_depth));
    chk("AFULL",      32'(o_af),  32'(mq.size() >= m_af));
    chk("AEMPTY",     32'(o_ae),  32'(mq.size() <= m_ae));
    chk("OVERFLOW",   32'(o_ov),  32'(m_ovf));
    chk("UNDERFLOW",  32'(o_ud),  32'(m_udf));
    chk("ERR_STICKY", 32'(o_st),  32'(m_sticky));
  endtask

  task automatic drive(input bit we, input logic [31:0] d, input bit re, input bit clr);
    ia.WE   = (sel == 0) && we;
    ia.RE   = (sel == 0) && re;
    ia.CLR  = (sel == 0) && clr;
    ia.DATA = d;
    ib.WE   = (sel == 1) && we;
    ib.RE   = (sel == 1) && re;
    ib.CLR  = (sel == 1) && clr;
    ib.DATA = d[7:0];
  endtask

  task automatic cyc(input bit we, input logic [31:0] d, input bit re, input bit clr);
    drive(we, d, re, clr);
    @(posedge clk);
    model_edge(we, d, re, clr);
    #1;
    check_all();
  endtask

  // Asserts RESET immediately (async), checks, holds for 'cycles' edges,
  // then releases it just after an edge.
  task automatic do_reset(input int cycles);
    drive(1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (cycles) begin
      @(posedge clk);
      #1;
      check_all();
    end
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && mq.size() > 0; k++) cyc(1'b0, '0, 1'b1, 1'b0);
    chk("drain_done", 32'(mq.size()), 32'd0);
  endtask

  task automatic random_run(input int n);
    bit we, re, clr;
    for (int i = 0; i < n; i++) begin
      if (i < n / 2) begin
        we = ($urandom_range(0, 99) < 75);
        re = ($urandom_range(0, 99) < 35);
      end else begin
        we = ($urandom_range(0, 99) < 35);
        re = ($urandom_range(0, 99) < 75);
      end
      clr = ($urandom_range(0, 63) == 0);
      cyc(we, $urandom, re, clr);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    sel = 0; m_fwft = 1'b1; m_depth = 64; m_af = 60; m_ae = 3; m_mask = 32'hFFFF_FFFF;
    model_reset();
    drive(1'b0, '0, 1'b0, 1'b0);
    #2;

    // ---- FWFT instance: reset and idle
    do_reset(5);
    chk("rst_q", o_q, 32'd0);
    chk("rst_empty", 32'(o_em), 32'd1);
    // first edge after release ignores the write
    cyc(1'b1, 32'h1111_1111, 1'b0, 1'b0);
    chk("ready_gate", o_cnt, 32'd0);

    // ---- FWFT basic
    cyc(1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
    chk("fwft_lat_empty", 32'(o_em), 32'd1);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("fwft_q", o_q, 32'hA5A5_0001);
    chk("fwft_empty", 32'(o_em), 32'd0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("pop_empty", 32'(o_em), 32'd1);
    chk("pop_count", o_cnt, 32'd0);

    // ---- fill to full, overflow, drain in order
    for (int i = 0; i < 64; i++) begin
      cyc(1'b1, 32'(i), 1'b0, 1'b0);
      if (i == 58) chk("afull_59", 32'(o_af), 32'd0);
      if (i == 59) chk("afull_60", 32'(o_af), 32'd1);
    end
    chk("full_64", 32'(o_fu), 32'd1);
    cyc(1'b1, 32'h0000_DEAD, 1'b0, 1'b0);
    chk("ovf_pulse", 32'(o_ov), 32'd1);
    chk("sticky_ovf", 32'(o_st), 32'd2);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("ovf_single", 32'(o_ov), 32'd0);
    for (int i = 0; i < 64; i++) begin
      chk("drain_seq", o_q, 32'(i));
      cyc(1'b0, '0, 1'b1, 1'b0);
      if (63 - i == 4) chk("aempty_4", 32'(o_ae), 32'd0);
      if (63 - i == 3) chk("aempty_3", 32'(o_ae), 32'd1);
    end
    chk("drained_empty", 32'(o_em), 32'd1);

    // ---- simultaneous read and write at the boundaries
    for (int i = 0; i < 64; i++) cyc(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
    cyc(1'b1, 32'h0000_BEEF, 1'b1, 1'b0);
    chk("full_rw_count", o_cnt, 32'd63);
    chk("full_rw_ovf", 32'(o_ov), 32'd1);
    drain();
    cyc(1'b1, 32'h5A5A_5A5A, 1'b1, 1'b0);
    chk("empty_rw_count", o_cnt, 32'd1);
    chk("empty_rw_udf", 32'(o_ud), 32'd1);

    // ---- CLR with simultaneous write
    for (int i = 0; i < 9; i++) cyc(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
    chk("ten_held", o_cnt, 32'd10);
    cyc(1'b1, 32'h0000_0077, 1'b0, 1'b1);
    chk("clr_count", o_cnt, 32'd0);
    chk("clr_sticky", 32'(o_st), 32'd0);
    chk("clr_empty", 32'(o_em), 32'd1);

    // ---- refill, then asynchronous reset mid-cycle
    for (int i = 0; i < 10; i++) cyc(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    #3;
    do_reset(3);
    chk("async_count", o_cnt, 32'd0);
    cyc(1'b0, '0, 1'b0, 1'b0);

    random_run(600);

    // ---- standard-read instance
    sel = 1; m_fwft = 1'b0; m_depth = 4; m_af = 3; m_ae = 1; m_mask = 32'h0000_00FF;
    @(posedge clk);
    #1;
    do_reset(5);
    cyc(1'b0, '0, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) cyc(1'b1, 32'(i), 1'b0, 1'b0);
    chk("std_ovf", 32'(o_ov), 32'd1);
    chk("std_sticky_ovf", 32'(o_st), 32'd2);
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b0, '0, 1'b1, 1'b0);
      if (i <= 4) begin
        chk("std_q", o_q, 32'(i));
        chk("std_dvld", 32'(o_dv), 32'd1);
      end else begin
        chk("std_udf", 32'(o_ud), 32'd1);
        chk("std_dvld_udf", 32'(o_dv), 32'd0);
        chk("std_sticky_both", 32'(o_st), 32'd3);
      end
    end
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("std_q_hold", o_q, 32'd4);
    cyc(1'b1, 32'd6, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("std_wrap_q", o_q, 32'd6);

    random_run(400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ack_fifo_sync.md
Name: ack_fifo_sync

Overview:
- Parametrised single-clock FIFO; next generation of the 32x64 acknowledge FIFO between the HDC classifier core and the radio/ack path.
- Generalises width, depth and read mode (first-word-fall-through or registered standard read).
- Adds programmable almost-full/almost-empty thresholds, occupancy count, underflow detection, sticky error flags and a synchronous flush.

Parameters:
- WIDTH, 32, data word width in bits (1..256).
- DEPTH, 64, number of entries; power of two, 4..4096.
- FWFT, 1, 1 = first-word-fall-through; 0 = standard read with one-cycle latency.
- AFVAL, 60, AFULL asserts when count >= AFVAL (1..DEPTH-1).
- AEVAL, 3, AEMPTY asserts when count <= AEVAL (0..DEPTH-2).

Ports:
- CLK  in  1  rising-edge clock.
- RESET  in  1  asynchronous active-low reset.
- CLR  in  1  synchronous flush, active high.
- WE  in  1  write request, active high.
- DATA  in  WIDTH  write data.
- RE  in  1  read/pop request, active high.
- Q  out  WIDTH  read data.
- DVLD  out  1  Q valid (FWFT: equals !EMPTY; standard: one-cycle pulse).
- FULL  out  1  count == DEPTH.
- EMPTY  out  1  no word available to the reader.
- AFULL  out  1  almost full.
- AEMPTY  out  1  almost empty.
- COUNT  out  log2(DEPTH)+1  words held, including the FWFT head word.
- OVERFLOW  out  1  one-cycle pulse, write rejected.
- UNDERFLOW  out  1  one-cycle pulse, read rejected.
- ERR_STICKY  out  2  [1] = overflow seen, [0] = underflow seen; cleared only by RESET or CLR.

Behaviour:
- Reset (RESET low, asynchronous): pointers and COUNT = 0; EMPTY = 1, AEMPTY = 1; FULL, AFULL, DVLD, OVERFLOW, UNDERFLOW = 0; ERR_STICKY = 0; Q = 0. Memory contents are not reset.
- Reset release: deassertion is synchronised internally; first accepted write is on the second CLK edge after RESET rises.
- Write acceptance: wr_ok = WE & !FULL, using FULL as registered at that edge. A read in the same cycle does not make room for the write.
- Read acceptance: rd_ok = RE & !EMPTY. A write in the same cycle does not satisfy the read.
- COUNT update: +1 on wr_ok only; -1 on rd_ok only; unchanged when both or neither occur.
- Flags: all flags are registered and derived from next-count.
  - FULL, AFULL, AEMPTY and COUNT change on the same edge as the access that moves them.
- EMPTY in FWFT mode:
  - First write into an empty FIFO: EMPTY falls one cycle after the write edge, with Q = that word in the same cycle.
  - While EMPTY = 0, Q holds the head word.
  - rd_ok pops it; the next word appears on Q the following cycle, or EMPTY rises if none remain.
  - Back-to-back pops sustain one word per cycle.
- EMPTY in standard mode:
  - EMPTY = (count == 0).
  - rd_ok at edge N: Q = word and DVLD = 1 at edge N+1.
  - Q holds its last value otherwise; DVLD = 0 otherwise.
- Errors:
  - WE & FULL: OVERFLOW pulses high for the cycle after that edge; ERR_STICKY[1] sets; data is dropped; pointers are unchanged.
  - RE & EMPTY: UNDERFLOW pulses likewise; ERR_STICKY[0] sets; Q is unchanged.
- Pointers: log2(DEPTH) bits with natural wrap-around from DEPTH-1 to 0; no special case at the wrap.
- CLR: empties the FIFO as reset does (Q retained), on the same edge. CLR has priority over a simultaneous WE/RE, which are ignored and flag no error.
- Memory: a simple dual-port array, written on wr_ok; the read address comes from the read pointer.
  - The FWFT head register is prefetched from the array.
  - The array must map to RTG4/SmartFusion2 LSRAM/uSRAM inference.

Test Plan:
- Reset then idle: hold RESET low 5 cycles, release -> EMPTY=1, AEMPTY=1, COUNT=0, Q=0, all other flags 0.
- FWFT basic, defaults: write 0xA5A5_0001 once -> one cycle later EMPTY=0 and Q=0xA5A5_0001; pulse RE -> EMPTY=1 next cycle, COUNT=0.
- Fill to full, DEPTH=64: write 0..63 -> AFULL rises when COUNT reaches 60, FULL at 64. Write 0xDEAD -> OVERFLOW pulses, ERR_STICKY=2'b10. Read all 64 words -> sequence 0..63, 0xDEAD absent; AEMPTY rises at COUNT=3.
- Simultaneous read and write:
  - Full + RE + WE -> read accepted, write rejected, OVERFLOW pulse, COUNT=63.
  - Empty + RE + WE -> write accepted, UNDERFLOW pulse, COUNT=1.
- Standard mode (FWFT=0, WIDTH=8, DEPTH=4): write 1,2,3,4,5 then read 5 times -> DVLD/Q = 1,2,3,4 each one cycle after RE; 5th read gives UNDERFLOW, ERR_STICKY=2'b11. After wrap, write 6 and read it -> Q=6.
- CLR and reset mid-operation: with 10 words held, CLR together with WE -> COUNT=0, EMPTY=1, ERR_STICKY=0. Refill 10 words, assert RESET asynchronously mid-cycle -> flags return to reset values immediately, without waiting for a CLK edge.
